// File: rtl/axis_broadcast_mask.sv
// AXI4-Stream 1-to-F broadcast with a per-packet destination mask.
// Each output owns a one-beat register slice; empty-mask packets are dropped.
module axis_broadcast_mask #(
  parameter int F  = 4,
  parameter int N  = 8,
  parameter int U  = 1,
  parameter int I  = 1,
  parameter int D  = 1,
  parameter int CW = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [F-1:0]     en,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [8*N-1:0]   s_tdata,
  input  logic [N-1:0]     s_tstrb,
  input  logic [N-1:0]     s_tkeep,
  input  logic             s_tlast,
  input  logic [U-1:0]     s_tuser,
  input  logic [I-1:0]     s_tid,
  input  logic [D-1:0]     s_tdest,
  input  logic [F-1:0]     s_tmask,
  output logic [F-1:0]     m_tvalid,
  input  logic [F-1:0]     m_tready,
  output logic [F*8*N-1:0] m_tdata,
  output logic [F*N-1:0]   m_tstrb,
  output logic [F*N-1:0]   m_tkeep,
  output logic [F-1:0]     m_tlast,
  output logic [F*U-1:0]   m_tuser,
  output logic [F*I-1:0]   m_tid,
  output logic [F*D-1:0]   m_tdest,
  output logic [CW-1:0]    drop_count
);

  logic [F-1:0]     vld_q, vld_d;
  logic             sop_q, sop_d;
  logic [F-1:0]     mask_q, mask_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [F*8*N-1:0] data_q;
  logic [F*N-1:0]   strb_q, keep_q;
  logic [F-1:0]     last_q;
  logic [F*U-1:0]   user_q;
  logic [F*I-1:0]   id_q;
  logic [F*D-1:0]   dest_q;

  logic [F-1:0] emask;
  logic [F-1:0] free;
  logic         acc;

  assign emask    = sop_q ? (s_tmask & en) : mask_q;
  assign free     = ~vld_q | m_tready;
  assign s_tready = ~areset & (&(free | ~emask));
  assign acc      = s_tvalid & s_tready;

  // Next-state for slot valids, packet tracking and the drop counter
  always_comb begin
    vld_d  = vld_q;
    sop_d  = sop_q;
    mask_d = mask_q;
    drop_d = drop_q;
    for (int j = 0; j < F; j++) begin
      if (acc && emask[j]) vld_d[j] = 1'b1;
      else if (m_tready[j]) vld_d[j] = 1'b0;
    end
    if (acc) begin
      sop_d = s_tlast;
      if (sop_q) begin
        mask_d = emask;
        if (emask == '0 && drop_q != {CW{1'b1}})
          drop_d = drop_q + 1'b1;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q  <= '0;
      sop_q  <= 1'b1;
      mask_q <= '0;
      drop_q <= '0;
    end else begin
      vld_q  <= vld_d;
      sop_q  <= sop_d;
      mask_q <= mask_d;
      drop_q <= drop_d;
    end
  end

  // Payload slices load only for outputs selected by the beat's mask
  always_ff @(posedge aclk) begin
    for (int j = 0; j < F; j++) begin
      if (acc && emask[j]) begin
        data_q[j*8*N +: 8*N] <= s_tdata;
        strb_q[j*N +: N]     <= s_tstrb;
        keep_q[j*N +: N]     <= s_tkeep;
        last_q[j]            <= s_tlast;
        user_q[j*U +: U]     <= s_tuser;
        id_q[j*I +: I]       <= s_tid;
        dest_q[j*D +: D]     <= s_tdest;
      end
    end
  end

  assign m_tvalid   = vld_q;
  assign m_tdata    = data_q;
  assign m_tstrb    = strb_q;
  assign m_tkeep    = keep_q;
  assign m_tlast    = last_q;
  assign m_tuser    = user_q;
  assign m_tid      = id_q;
  assign m_tdest    = dest_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_axis_broadcast_mask.sv
// Bench for axis_broadcast_mask: directed scenarios plus random traffic
// compared against a per-output queue model every cycle.
module tb_axis_broadcast_mask;
  localparam int F = 4;
  localparam int N = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        id;
    logic        dest;
  } beat_t;

  logic          aclk = 0;
  logic          areset;
  logic [F-1:0]  en;
  logic          s_tvalid;
  logic          s_tready, s_tready2;
  logic [63:0]   s_tdata;
  logic [7:0]    s_tstrb, s_tkeep;
  logic          s_tlast, s_tuser, s_tid, s_tdest;
  logic [F-1:0]  s_tmask;
  logic [F-1:0]  m_tvalid, m_tvalid2;
  logic [F-1:0]  m_tready;
  logic [255:0]  m_tdata, m_tdata2;
  logic [31:0]   m_tstrb, m_tkeep, m_tstrb2, m_tkeep2;
  logic [F-1:0]  m_tlast, m_tuser, m_tid, m_tdest;
  logic [F-1:0]  m_tlast2, m_tuser2, m_tid2, m_tdest2;
  logic [15:0]   drop_count;
  logic [1:0]    drop_count2;

  always #5 aclk = ~aclk;

  axis_broadcast_mask #(.F(F), .N(N), .U(1), .I(1), .D(1), .CW(16)) dut (
    .aclk(aclk), .areset(areset), .en(en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tid(s_tid), .s_tdest(s_tdest),
    .s_tmask(s_tmask), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
    .m_tdest(m_tdest), .drop_count(drop_count)
  );

  axis_broadcast_mask #(.F(F), .N(N), .U(1), .I(1), .D(1), .CW(2)) dut2 (
    .aclk(aclk), .areset(areset), .en(en),
    .s_tvalid(s_tvalid), .s_tready(s_tready2), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tid(s_tid), .s_tdest(s_tdest),
    .s_tmask(s_tmask), .m_tvalid(m_tvalid2), .m_tready(m_tready),
    .m_tdata(m_tdata2), .m_tstrb(m_tstrb2), .m_tkeep(m_tkeep2),
    .m_tlast(m_tlast2), .m_tuser(m_tuser2), .m_tid(m_tid2),
    .m_tdest(m_tdest2), .drop_count(drop_count2)
  );

  int errors = 0;
  int checks = 0;

  beat_t        expq [F][$];
  logic         m_sop;
  logic [F-1:0] m_mask;
  int           m_drops;
  int           n_acc;
  logic         last_acc;

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [F-1:0] cur_emask();
    return m_sop ? (s_tmask & en) : m_mask;
  endfunction

  function automatic logic exp_ready();
    logic [F-1:0] em;
    logic r;
    em = cur_emask();
    r = !areset;
    for (int j = 0; j < F; j++)
      if (em[j] && expq[j].size() != 0 && !m_tready[j]) r = 0;
    return r;
  endfunction

  // Compare every visible output against the model, then advance it
  task automatic check_and_update();
    logic [F-1:0] em;
    logic rdy;
    beat_t b, h;
    em  = cur_emask();
    rdy = exp_ready();
    cmp("s_tready", s_tready, rdy);
    cmp("drop_count", drop_count, m_drops > 65535 ? 65535 : m_drops);
    cmp("drop_sat", drop_count2, m_drops > 3 ? 3 : m_drops);
    for (int j = 0; j < F; j++) begin
      cmp($sformatf("m_tvalid[%0d]", j), m_tvalid[j], expq[j].size() != 0);
      if (expq[j].size() != 0 && m_tvalid[j]) begin
        b = expq[j][0];
        h = '{m_tdata[j*64 +: 64], m_tstrb[j*8 +: 8], m_tkeep[j*8 +: 8],
              m_tlast[j], m_tuser[j], m_tid[j], m_tdest[j]};
        if (h !== b) begin
          errors++;
          $display("FAIL payload[%0d]: got %h expected %h", j, h, b);
        end
        checks++;
      end
    end
    last_acc = 0;
    if (areset) begin
      for (int j = 0; j < F; j++) expq[j].delete();
      m_sop = 1; m_mask = 0; m_drops = 0;
      return;
    end
    for (int j = 0; j < F; j++)
      if (expq[j].size() != 0 && m_tready[j]) void'(expq[j].pop_front());
    if (s_tvalid && rdy) begin
      last_acc = 1;
      n_acc++;
      b = '{s_tdata, s_tstrb, s_tkeep, s_tlast, s_tuser, s_tid, s_tdest};
      for (int j = 0; j < F; j++) if (em[j]) expq[j].push_back(b);
      if (m_sop && em == 0) m_drops++;
      if (m_sop) m_mask = em;
      m_sop = s_tlast;
    end
  endtask

  task automatic step();
    #1;
    check_and_update();
    @(negedge aclk);
  endtask

  task automatic new_beat(logic v, logic last, logic [F-1:0] mask);
    s_tvalid = v;
    s_tlast  = last;
    s_tmask  = mask;
    s_tdata  = {$urandom, $urandom};
    s_tstrb  = 8'($urandom);
    s_tkeep  = 8'($urandom);
    s_tuser  = 1'($urandom);
    s_tid    = 1'($urandom);
    s_tdest  = 1'($urandom);
  endtask

  initial begin
    int a0;
    int pr;
    m_sop = 1; m_mask = 0; m_drops = 0; n_acc = 0; last_acc = 0;
    areset = 1; en = 4'hF; m_tready = 4'hF;
    new_beat(0, 0, 4'h0);
    @(negedge aclk);
    step();
    cmp("rst_tready", s_tready, 1'b0);
    cmp("rst_tvalid", m_tvalid, 4'h0);
    cmp("rst_drops", drop_count, 16'd0);
    areset = 0;

    // all outputs selected, all ready, one 8-beat packet
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      new_beat(1, i == 7, 4'hF);
      step();
      cmp("t1_tvalid", m_tvalid, 4'hF);
    end
    cmp("t1_accepts", n_acc - a0, 8);
    new_beat(0, 0, 4'h0);
    step();

    // 3 four-beat packets with en=0 dropped, then two more single-beat drops
    en = 4'h0;
    a0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      new_beat(1, (i % 4) == 3, 4'hF);
      step();
      cmp("t4_tvalid", m_tvalid, 4'h0);
    end
    cmp("t4_accepts", n_acc - a0, 12);
    cmp("t4_drops", drop_count, 16'd3);
    for (int i = 0; i < 2; i++) begin
      new_beat(1, 1, 4'hF);
      step();
    end
    cmp("t4_drops5", drop_count, 16'd5);
    cmp("t4_sat", drop_count2, 2'd3);
    new_beat(0, 0, 4'h0);
    en = 4'hF;
    step();

    // mid-packet reset with all outputs stalled full
    new_beat(1, 0, 4'hF);
    m_tready = 4'h0;
    step();
    cmp("t6_full", m_tvalid, 4'hF);
    areset = 1;
    step();
    cmp("t6_cleared", m_tvalid, 4'h0);
    cmp("t6_drops", drop_count, 16'd0);
    areset = 0;
    m_tready = 4'hF;
    new_beat(1, 1, 4'b0010);
    step();
    cmp("t6_fresh", m_tvalid, 4'b0010);
    new_beat(0, 0, 4'h0);
    step();

    // random traffic in phases of varying consumer speed
    for (int c = 0; c < 6000; c++) begin
      pr = (c / 1000) % 3;
      if (!(s_tvalid && !last_acc)) begin
        if ($urandom_range(0, 15) == 0) en = 4'($urandom);
        new_beat($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                 4'($urandom));
      end
      for (int j = 0; j < F; j++) begin
        if (pr == 0) m_tready[j] = 1'b1;
        else if (pr == 1) m_tready[j] = $urandom_range(0, 9) < 8;
        else m_tready[j] = (j == 0) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 1) == 0);
      end
      areset = ($urandom_range(0, 499) == 0);
      step();
    end
    areset = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
